// File: rtl/user_pulse_monitor.sv
// Observer for the user-domain pulser output. It measures each complete high and
// low segment of pulse_i, queues the measurements in a FIFO and counts rising edges.
module user_pulse_monitor #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     en_i,
   input  logic                     clear_i,
   input  logic                     pulse_i,
   output logic                     rec_valid_o,
   input  logic                     rec_ready_i,
   output logic                     rec_level_o,
   output logic [CNT_W-1:0]         rec_len_o,
   output logic                     rec_sat_o,
   output logic [$clog2(DEPTH):0]   fill_o,
   output logic                     overflow_o,
   output logic [15:0]              edge_cnt_o
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned REC_W = CNT_W + 2;

   localparam logic [CNT_W-1:0] LEN_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] LEN_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [AW:0]      FILL_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0]      FILL_FULL = (AW+1)'(DEPTH);
   localparam logic [AW-1:0]    PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SYNC  = 2'd1,
      ST_TRACK = 2'd2
   } state_e;

   state_e             state_r, state_s;
   logic               lvl_r, lvl_s;
   logic [CNT_W-1:0]   len_r, len_s;
   logic               sat_r, sat_s;
   logic               push_s;
   logic               rise_s;

   logic [REC_W-1:0]   mem_r [DEPTH];
   logic [AW-1:0]      wr_ptr_r, rd_ptr_r;
   logic [AW:0]        fill_r;
   logic               overflow_r;
   logic [15:0]        edge_cnt_r;
   logic               pop_s, full_s, wr_s, drop_s;
   logic [REC_W-1:0]   head_s;

   // Segment tracker: next state, segment length and record push request.
   always_comb begin
      state_s = state_r;
      lvl_s   = lvl_r;
      len_s   = len_r;
      sat_s   = sat_r;
      push_s  = 1'b0;
      rise_s  = 1'b0;
      if (clear_i) begin
         state_s = ST_IDLE;
      end else begin
         rise_s = (state_r != ST_IDLE) && pulse_i && !lvl_r;
         case (state_r)
            ST_IDLE: begin
               if (en_i) begin
                  state_s = ST_SYNC;
                  lvl_s   = pulse_i;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            // The first edge after enabling starts the first fully observed segment.
            ST_SYNC: begin
               if (!en_i) begin
                  state_s = ST_IDLE;
               end else if (pulse_i != lvl_r) begin
                  state_s = ST_TRACK;
                  lvl_s   = pulse_i;
                  len_s   = LEN_ONE;
                  sat_s   = 1'b0;
               end else begin
                  state_s = ST_SYNC;
               end
            end
            ST_TRACK: begin
               if (!en_i) begin
                  state_s = ST_IDLE;
               end else if (pulse_i == lvl_r) begin
                  if (len_r == LEN_MAX) begin
                     sat_s = 1'b1;
                  end else begin
                     len_s = len_r + LEN_ONE;
                  end
               end else begin
                  push_s = 1'b1;
                  lvl_s  = pulse_i;
                  len_s  = LEN_ONE;
                  sat_s  = 1'b0;
               end
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end
   end

   // Segment tracker state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= ST_IDLE;
         lvl_r   <= 1'b0;
         len_r   <= {CNT_W{1'b0}};
         sat_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         lvl_r   <= lvl_s;
         len_r   <= len_s;
         sat_r   <= sat_s;
      end
   end

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign full_s = (fill_r == FILL_FULL);
   assign pop_s  = (fill_r != {(AW+1){1'b0}}) && rec_ready_i && !clear_i;
   assign wr_s   = push_s && (!full_s || pop_s);
   assign drop_s = push_s && full_s && !pop_s;

   // FIFO pointers, occupancy, sticky overflow and rising-edge counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_r   <= {AW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         fill_r     <= {(AW+1){1'b0}};
         overflow_r <= 1'b0;
         edge_cnt_r <= 16'd0;
      end else if (clear_i) begin
         wr_ptr_r   <= {AW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         fill_r     <= {(AW+1){1'b0}};
         overflow_r <= 1'b0;
         edge_cnt_r <= 16'd0;
      end else begin
         if (wr_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         if (wr_s && !pop_s) begin
            fill_r <= fill_r + FILL_ONE;
         end else if (!wr_s && pop_s) begin
            fill_r <= fill_r - FILL_ONE;
         end
         if (drop_s) begin
            overflow_r <= 1'b1;
         end
         if (rise_s) begin
            edge_cnt_r <= edge_cnt_r + 16'd1;
         end
      end
   end

   // Record storage; contents are only visible through a valid head.
   always_ff @(posedge clk_i) begin
      if (wr_s) begin
         mem_r[wr_ptr_r] <= {lvl_r, sat_r, len_r};
      end
   end

   assign head_s = mem_r[rd_ptr_r];

   // First-word-fall-through head; fields read as zero while empty.
   always_comb begin
      rec_valid_o = (fill_r != {(AW+1){1'b0}});
      rec_level_o = 1'b0;
      rec_sat_o   = 1'b0;
      rec_len_o   = {CNT_W{1'b0}};
      if (rec_valid_o) begin
         rec_level_o = head_s[REC_W-1];
         rec_sat_o   = head_s[REC_W-2];
         rec_len_o   = head_s[CNT_W-1:0];
      end else begin
         rec_level_o = 1'b0;
      end
   end

   assign fill_o     = fill_r;
   assign overflow_o = overflow_r;
   assign edge_cnt_o = edge_cnt_r;

endmodule
